mult_scheduler: RTL

//  Shares one iterative shift-add multiplier between two requesters in the pedal datapath.

---
 rtl/mult_scheduler_pkg.sv | 25 ++
 rtl/mult_scheduler_if.sv | 40 ++++
 rtl/mult_scheduler_mult.sv | 57 +++++
 rtl/mult_scheduler.sv | 138 +++++++++++++
 4 files changed

// File: rtl/mult_scheduler_pkg.sv
// Shared types for the two-requester multiplier scheduler.
// Holds FSM states, requester ids and default widths.
package mult_sched_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int FRAC_DEF  = 15;

  localparam logic REQ_GAIN = 1'b0;
  localparam logic REQ_FB   = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  // Context latched at the handshake and
  // carried through to the result.
  typedef struct packed {
    logic sign;
    logic id;
  } job_t;

endpackage

// File: rtl/mult_scheduler_if.sv
// Request/result handshake bundle for mult_scheduler.
// master: requesters + consumer side; slave: scheduler side.
interface mult_scheduler_if
  import mult_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_id;

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_data, res_id
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_data, res_id
  );

endinterface

// File: rtl/mult_scheduler_mult.sv
// Unsigned iterative shift-add multiplier, one bit per cycle.
// Ports: clk, rst_n, start, a, b -> done, product.
module shift_add_mult
  import mult_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CW-1:0]    cnt_q;
  logic [PW-1:0]    acc_d;

  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (start) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      cnt_q    <= CW'(WIDTH);
    end else if (cnt_q != '0) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CW'(1);
    end
  end

  // High during the final iteration; product is
  // complete on the following cycle.
  assign done    = (cnt_q == CW'(1));
  assign product = acc_q;

endmodule

// File: rtl/mult_scheduler.sv
// Round-robin share of one shift-add multiplier, signed Q1.15.
// Ports: clk, rst_n, bus (slave: req0/req1/res), busy.
module mult_scheduler
  import mult_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  mult_scheduler_if.slave  bus,
  output logic             busy
);

  localparam int PW = 2 * WIDTH;

  localparam logic signed [PW-1:0] MAXV =
    {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV =
    {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  state_t state_q;
  state_t state_d;

  logic             last_q;
  job_t             job_q;
  logic [WIDTH-1:0] res_q;
  logic             rid_q;

  logic             idle;
  logic             g0;
  logic             g1;
  logic             hs;
  logic             grant_id;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  logic             core_done;
  logic [PW-1:0]    core_prod;

  logic signed [PW-1:0] prod_s;
  logic signed [PW-1:0] shf_s;
  logic [WIDTH-1:0]     sat;

  // Gated by rst_n so ready is low while reset
  // is held even with a requester valid.
  assign idle = (state_q == IDLE) && rst_n;

  always_comb begin
    g0 = bus.req0_valid &&
         (!bus.req1_valid || last_q);
    g1 = bus.req1_valid &&
         (!bus.req0_valid || !last_q);
  end

  assign bus.req0_ready = idle && g0;
  assign bus.req1_ready = idle && g1;

  assign hs = (bus.req0_valid && bus.req0_ready) ||
              (bus.req1_valid && bus.req1_ready);

  assign grant_id = bus.req1_ready ? REQ_FB : REQ_GAIN;

  always_comb begin
    sel_a = grant_id ? bus.req1_a : bus.req0_a;
    sel_b = grant_id ? bus.req1_b : bus.req0_b;
    // -MIN wraps back to 0x8000, which is the
    // correct unsigned magnitude.
    mag_a = sel_a[WIDTH-1] ? (~sel_a + 1'b1) : sel_a;
    mag_b = sel_b[WIDTH-1] ? (~sel_b + 1'b1) : sel_b;
  end

  shift_add_mult #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (hs),
    .a       (mag_a),
    .b       (mag_b),
    .done    (core_done),
    .product (core_prod)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (hs) state_d = RUN;
      RUN:  if (core_done) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Magnitude product fits in PW-1 bits, so the
  // negation cannot overflow.
  always_comb begin
    prod_s = job_q.sign ? -$signed(core_prod)
                        : $signed(core_prod);
    shf_s  = prod_s >>> FRAC;
    sat    = shf_s[WIDTH-1:0];
    unique case (1'b1)
      (shf_s > MAXV): sat = {1'b0, {(WIDTH-1){1'b1}}};
      (shf_s < MINV): sat = {1'b1, {(WIDTH-1){1'b0}}};
      default:        sat = shf_s[WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      job_q   <= '0;
      res_q   <= '0;
      rid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        last_q     <= grant_id;
        job_q.sign <= sel_a[WIDTH-1] ^ sel_b[WIDTH-1];
        job_q.id   <= grant_id;
      end
      if (state_q == FIX) begin
        res_q <= sat;
        rid_q <= job_q.id;
      end
    end
  end

  assign bus.res_valid = (state_q == DONE);
  assign bus.res_data  = res_q;
  assign bus.res_id    = rid_q;
  assign busy          = (state_q != IDLE);

endmodule
